// File: rtl/alu_muldiv_sequencer.sv
// rtl/alu_muldiv_sequencer.sv - shift-add multiply / restoring divide sequencer over the shared MICRO-1 ALU
package micro1_pkg;
  localparam int MICRO1_MACHINE_WORD = 16;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_operation_t;
endpackage

module alu_muldiv_sequencer
  import micro1_pkg::*;
#(
  parameter int WIDTH = MICRO1_MACHINE_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_hi,
  output logic [WIDTH-1:0]     resp_lo,
  output logic                 resp_dbz,
  output alu_operation_t       alu_operation,
  output logic [WIDTH-1:0]     alu_left,
  output logic [WIDTH-1:0]     alu_right,
  output logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] resp_hi_q, resp_hi_d;
  logic [WIDTH-1:0] resp_lo_q, resp_lo_d;
  logic             resp_dbz_q, resp_dbz_d;

  logic             stepping;
  logic [WIDTH-1:0] div_s;

  // acc_hi/acc_lo hold P for MUL and R/Q for DIV; m holds M or D.
  assign stepping = (state_q == RUN) && (cnt_q < CW'(WIDTH));
  assign div_s    = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_hi    = resp_hi_q;
  assign resp_lo    = resp_lo_q;
  assign resp_dbz   = resp_dbz_q;

  always_comb begin
    alu_operation = ALU_NOP;
    alu_left      = '0;
    alu_right     = '0;
    alu_cin       = 1'b0;
    if (stepping) begin
      if (op_q) begin
        alu_operation = ALU_SUB;
        alu_left      = div_s;
        alu_right     = m_q;
      end else begin
        alu_operation = ALU_ADD;
        alu_left      = acc_hi_q;
        alu_right     = acc_lo_q[0] ? m_q : '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dbz_d      = dbz_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    m_d        = m_q;
    resp_hi_d  = resp_hi_q;
    resp_lo_d  = resp_lo_q;
    resp_dbz_d = resp_dbz_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = RUN;
          cnt_d    = '0;
          op_d     = req_op;
          dbz_d    = req_op && (req_b == '0);
          acc_hi_d = '0;
          acc_lo_d = req_op ? req_a : req_b;
          m_d      = req_op ? req_b : req_a;
        end
      end
      RUN: begin
        // One settling cycle after the last step latches the results.
        if (!stepping) begin
          state_d    = DONE;
          resp_hi_d  = acc_hi_q;
          resp_lo_d  = acc_lo_q;
          resp_dbz_d = dbz_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_q) begin
            if (!alu_cout) begin
              acc_hi_d = alu_result;
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_d = div_s;
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_d = {alu_cout, alu_result[WIDTH-1:1]};
            acc_lo_d = {alu_result[0], acc_lo_q[WIDTH-1:1]};
          end
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      dbz_q      <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      m_q        <= '0;
      resp_hi_q  <= '0;
      resp_lo_q  <= '0;
      resp_dbz_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dbz_q      <= dbz_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      m_q        <= m_d;
      resp_hi_q  <= resp_hi_d;
      resp_lo_q  <= resp_lo_d;
      resp_dbz_q <= resp_dbz_d;
    end
  end

endmodule
